inst_fetch_unit: RTL and testbench



---
 rtl/inst_fetch_unit.sv | 99 +++++++++
 tb/tb_inst_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: sequential PC generation, req/gnt/rvalid memory port,
// response FIFO feeding IF/ID, stall and ex-stage jump redirect handling.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stalled_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        req_o,
  output logic [31:0] addr_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);

  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] drop_cnt;
  logic [31:0]   resp_pc;
  logic [31:0]   jump_pc;
  logic          credit;
  logic          accept;
  logic          push;
  logic          pop;

  // every outstanding request owns a FIFO slot, so push never overflows
  assign credit   = (outstanding + count) < CAP;
  assign req_o    = rst_n && credit;
  assign accept   = credit && gnt_i;
  assign out_next = outstanding + CW'(accept) - CW'(rvalid_i);
  assign jump_pc  = {jump_addr_i[31:2], 2'b00};

  assign valid_o = count != '0;
  assign pop     = valid_o && !stalled_i && !jump_flag_i;
  assign push    = rvalid_i && !jump_flag_i && (drop_cnt == '0);
  assign pc_o    = valid_o ? fifo_pc[rd_ptr] : '0;
  assign inst_o  = valid_o ? fifo_inst[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_o      <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= out_next;
      if (jump_flag_i) begin
        // in-flight requests, including this cycle's grant, are dropped
        addr_o   <= jump_pc;
        resp_pc  <= jump_pc;
        drop_cnt <= out_next;
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (accept) begin
          addr_o <= addr_o + 32'd4;
        end
        if (rvalid_i && drop_cnt != '0) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if (push) begin
          wr_ptr  <= wr_ptr + PW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= resp_pc;
      fifo_inst[wr_ptr] <= rdata_i;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: queue-based reference model checked every
// cycle, an in-order memory responder, and directed literal checks.
module tb_inst_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stalled_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic        req_o;
  logic [31:0] addr_o;
  logic        gnt_i;
  logic        rvalid_i = 1'b0;
  logic [31:0] rdata_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  int checks = 0;
  int failures = 0;
  bit mem_hold = 1'b0;
  logic [31:0] mem_q[$];

  inst_fetch_unit #(
    .RESET_PC(32'h0),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stalled_i(stalled_i),
    .jump_flag_i(jump_flag_i),
    .jump_addr_i(jump_addr_i),
    .req_o(req_o),
    .addr_o(addr_o),
    .gnt_i(gnt_i),
    .rvalid_i(rvalid_i),
    .rdata_i(rdata_i),
    .pc_o(pc_o),
    .inst_o(inst_o),
    .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h0A00_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // in-order memory, at least one cycle after grant
  always @(posedge clk) begin
    #2;
    if (rst_n && !mem_hold && mem_q.size() > 0) begin
      rvalid_i = 1'b1;
      rdata_i  = mem_word(mem_q.pop_front());
    end else begin
      rvalid_i = 1'b0;
      rdata_i  = '0;
    end
  end

  // reference model: FIFO contents as a queue of {pc, inst}
  logic [63:0] mq[$];
  int          m_out;
  int          m_drop;
  int          nxt_out;
  logic [31:0] m_addr;
  logic [31:0] m_rpc;
  logic [63:0] head;
  bit          m_req;
  bit          m_valid;
  bit          acc;

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mem_q.delete();
      m_out  = 0;
      m_drop = 0;
      m_addr = 32'h0;
      m_rpc  = 32'h0;
      chk("rst_req", req_o, 0);
      chk("rst_addr", addr_o, 0);
      chk("rst_valid", valid_o, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_inst", inst_o, 0);
    end else begin
      m_req   = (m_out + mq.size()) < DEPTH;
      m_valid = mq.size() > 0;
      head    = m_valid ? mq[0] : 64'h0;
      chk("m_req", req_o, m_req);
      chk("m_addr", addr_o, m_addr);
      chk("m_valid", valid_o, m_valid);
      chk("m_pc", pc_o, head[63:32]);
      chk("m_inst", inst_o, head[31:0]);
      if (valid_o) chk("pair", inst_o, mem_word(pc_o));
      if (req_o && gnt_i) mem_q.push_back(addr_o);
      acc     = m_req && gnt_i;
      nxt_out = m_out + int'(acc) - int'(rvalid_i);
      if (jump_flag_i) begin
        mq.delete();
        m_drop = nxt_out;
        m_addr = jump_addr_i & 32'hFFFF_FFFC;
        m_rpc  = m_addr;
      end else begin
        if (acc) m_addr = m_addr + 32'd4;
        if (m_valid && !stalled_i) void'(mq.pop_front());
        if (rvalid_i) begin
          if (m_drop > 0) begin
            m_drop--;
          end else begin
            mq.push_back({m_rpc, rdata_i});
            m_rpc = m_rpc + 32'd4;
          end
        end
      end
      m_out = nxt_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    stalled_i   = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    gnt_i       = 1'b1;
    mem_hold    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // wait for a valid output whose pc differs from skip
  task automatic wait_valid(input string nm, input logic [31:0] skip);
    int n;
    n = 0;
    @(negedge clk);
    while (!(valid_o && pc_o != skip) && n < 12) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(valid_o && pc_o != skip)) begin
      failures++;
      $display("FAIL %s timeout valid=%b pc=%h", nm, valid_o, pc_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    stalled_i = 1'b0;
    jump_flag_i = 1'b0;
    jump_addr_i = '0;
    gnt_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("reset_req", req_o, 0);
    chk("reset_addr", addr_o, 0);
    chk("reset_valid", valid_o, 0);

    // sequential fetch with 1-cycle memory
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("c0_req", req_o, 1);
    chk("c0_addr", addr_o, 32'h0);
    tick();
    tick();
    @(negedge clk);
    chk("c2_valid", valid_o, 1);
    chk("c2_pc", pc_o, 32'h0);
    chk("c2_inst", inst_o, 32'h0A00_0013);
    tick();
    @(negedge clk);
    chk("c3_pc", pc_o, 32'h4);
    tick();
    @(negedge clk);
    chk("c4_bubble", valid_o, 0);
    tick();
    @(negedge clk);
    chk("c5_pc", pc_o, 32'h8);
    chk("c5_inst", inst_o, 32'h0A00_001B);

    // stall: head holds, credits run out
    tick();
    stalled_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_pc", pc_o, 32'hC);
      if (i >= 2) chk("stall_req", req_o, 0);
      tick();
    end
    stalled_i = 1'b0;
    @(negedge clk);
    chk("unstall_pc0", pc_o, 32'hC);
    tick();
    @(negedge clk);
    chk("unstall_pc1", pc_o, 32'h10);

    // jump with two requests outstanding, data held back
    tick();
    do_reset();
    mem_hold = 1'b1;
    tick();
    tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h100;
    @(negedge clk);
    chk("full_req", req_o, 0);
    tick();
    jump_flag_i = 1'b0;
    mem_hold = 1'b0;
    @(negedge clk);
    chk("jmp_addr", addr_o, 32'h100);
    chk("jmp_valid", valid_o, 0);
    wait_valid("jmp_first", 32'h1);
    chk("jmp_pc", pc_o, 32'h100);
    chk("jmp_inst", inst_o, 32'h0A00_0113);

    // jump coinciding with a response and a grant
    tick();
    do_reset();
    tick();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'h40;
    @(negedge clk);
    chk("coin_req", req_o, 1);
    tick();
    jump_flag_i = 1'b0;
    wait_valid("coin_first", 32'h1);
    chk("coin_pc", pc_o, 32'h40);
    chk("coin_inst", inst_o, 32'h0A00_0053);

    // grant withheld
    tick();
    do_reset();
    gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nogntreq", req_o, 1);
      chk("nogntaddr", addr_o, 32'h0);
      chk("nogntvalid", valid_o, 0);
      chk("nogntpc", pc_o, 32'h0);
      chk("nogntinst", inst_o, 32'h0);
      tick();
    end
    gnt_i = 1'b1;
    @(negedge clk);
    chk("gnt_addr0", addr_o, 32'h0);
    tick();
    @(negedge clk);
    chk("gnt_addr1", addr_o, 32'h4);

    // jump near the top of the address space
    tick();
    do_reset();
    jump_flag_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFE;
    tick();
    jump_flag_i = 1'b0;
    @(negedge clk);
    chk("wrap_addr", addr_o, 32'hFFFF_FFFC);
    chk("wrap_req", req_o, 1);
    tick();
    @(negedge clk);
    chk("wrap_next", addr_o, 32'h0);
    wait_valid("wrap_first", 32'h1);
    chk("wrap_pc", pc_o, 32'hFFFF_FFFC);
    chk("wrap_inst", inst_o, 32'hF5FF_FFEF);
    wait_valid("wrap_second", 32'hFFFF_FFFC);
    chk("wrap_pc2", pc_o, 32'h0);

    // mixed traffic, including back-to-back jumps
    tick();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      gnt_i       = $urandom_range(0, 3) != 0;
      stalled_i   = $urandom_range(0, 3) == 0;
      mem_hold    = $urandom_range(0, 2) == 0;
      jump_flag_i = $urandom_range(0, 11) == 0;
      jump_addr_i = $urandom;
      tick();
    end
    jump_flag_i = 1'b0;
    tick();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
